iqmu_sched: RTL and testbench
=============================

Name: iqmu_sched

Overview:
Round-robin scheduler that shares one iqmu (inverse quality modulating unit) instance between NUM_REQ feature streams in the synthesis/decoding path.
- Grants the iqmu to one requester at a time in bursts and drives that requester's data with its own quality mode.
- Carries a tag/last sideband through a delay line matched to the iqmu latency, so every dequantized word leaves labelled with its source stream.

Parameters:
NUM_REQ, 4, number of requesting streams (2..8)
DATA_W, 16, data word width; must match the iqmu instance
BURST_LEN, 16, maximum words per grant (2..256)
IQMU_LAT, 2, cycles from iq_valid/iq_data to the matching iq_data_out (1..4)
IDLE_TO, 8, consecutive no-valid cycles in a burst before the grant is dropped (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-stream word valid
req_last  in  NUM_REQ  per-stream end-of-frame, qualified by req_valid
req_data  in  NUM_REQ*DATA_W  per-stream word; stream i at [i*DATA_W +: DATA_W]
req_mode  in  NUM_REQ*2  per-stream quality mode; stream i at [2i +: 2]
req_ready  out  NUM_REQ  per-stream accept; one-hot or zero
iq_valid  out  1  to iqmu valid_in
iq_data  out  DATA_W  to iqmu data_in
iq_mode  out  2  to iqmu quality_mode
iq_valid_out  in  1  from iqmu valid_out, used for consistency checking only
iq_data_out  in  DATA_W  from iqmu data_out
out_valid  out  1  dequantized word valid
out_data  out  DATA_W  dequantized word (= iq_data_out)
out_tag  out  clog2(NUM_REQ)  source stream index
out_last  out  1  last word of burst
err_sync  out  1  sticky; iq_valid_out disagreed with the internal valid pipe

Behaviour:
- Reset: all outputs 0, FSM in IDLE, RR pointer 0, delay line cleared, err_sync 0. Reset asserted mid-burst aborts immediately; in-flight words are lost.
- FSM states:
  - IDLE: if any req_valid, pick the first set bit searching from ptr upward with wrap. Latch gnt, clear the word counter and idle counter, go to BURST. req_ready stays 0 in IDLE, so arbitration costs 1 cycle.
  - BURST: req_ready[gnt]=1 and all other req_ready bits 0.
    - Transfer when req_valid[gnt]: iq_valid=1, iq_data=req_data[gnt], iq_mode=req_mode[gnt], sampled in the same cycle, so each word carries its own mode. Word counter increments; idle counter clears.
    - End condition: the transfer is the BURST_LEN-th word, or req_last[gnt] is set.
    - On end: mark the transfer last, set ptr=gnt+1 (wrap), go to IDLE.
    - No transfer in a cycle: idle counter increments. On reaching IDLE_TO, go to IDLE with ptr=gnt+1; no last word is emitted.
- iq_valid/iq_data/iq_mode are combinational from the BURST state and the selected requester. iq_data is 0 when iq_valid is 0.
- Delay line: IQMU_LAT-stage register of {valid, tag, last}, loaded every cycle with {iq_valid, gnt, end-transfer}.
  - out_valid/out_tag/out_last are the final stage.
  - out_data = iq_data_out, combinational.
  - When out_valid=0: out_tag=0 and out_last=0.
- err_sync: set when iq_valid_out != the final-stage valid; cleared only by reset.
- No backpressure on the output side; the consumer must accept every out_valid.
- Fairness: a requester that keeps valid high gets at most BURST_LEN words before every other valid requester is served once.
- Single requester: bursts repeat back-to-back with a 1-cycle IDLE gap.

Optional Feature:
IQMU_SCHED_PERF_EN
- Defined: adds outputs perf_words (32 bits, total words issued to the iqmu) and perf_bursts (16 bits, grants issued). Both wrap, clear on reset, and increment on iq_valid and on each IDLE->BURST transition respectively.
- Undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Stream 0 only, mode 2, 20 words 0x0001..0x0014, no req_last:
  - Two bursts of 16 and 4 words.
  - out_data 0x0004, 0x0008, ... appears IQMU_LAT cycles after each iq_valid.
  - out_last on the 16th word.
  - After the 4th word of burst 2 the grant drops following 8 idle cycles.
- All 4 streams continuously valid, BURST_LEN=4:
  - Grant order 0,1,2,3,0.
  - out_tag sequence matches.
  - Exactly 4 words per grant with a 1-cycle IDLE gap between grants.
- Stream 1 mode 3 data 0x1000, stream 2 mode 0 data 0x8000, interleaved grants:
  - out_data 0x7FFF tagged 1.
  - out_data 0x8000 tagged 2.
  - No mode bleed between adjacent words.
- Stream 3 sends req_last on word 5 with other streams idle:
  - out_last on word 5 with out_tag=3.
  - req_ready[3] drops the next cycle.
  - ptr wraps so stream 0 is searched first.
- Force iq_valid_out low for one cycle during traffic:
  - err_sync rises and stays 1 until rst_n is pulsed.
  - rst_n asserted mid-burst clears all outputs asynchronously.
- IQMU_SCHED_PERF_EN defined, scenario 1 rerun: perf_words=20, perf_bursts=2.

Source files
------------

// File: rtl/iqmu_sched.sv
// iqmu_sched: round-robin burst scheduler sharing one iqmu between NUM_REQ streams.
// Define IQMU_SCHED_PERF_EN to add the perf_words / perf_bursts counters.
module iqmu_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 16,
  parameter int IQMU_LAT  = 2,
  parameter int IDLE_TO   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ*2-1:0]       req_mode,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       iq_valid,
  output logic [DATA_W-1:0]          iq_data,
  output logic [1:0]                 iq_mode,
  input  logic                       iq_valid_out,
  input  logic [DATA_W-1:0]          iq_data_out,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_tag,
  output logic                       out_last,
`ifdef IQMU_SCHED_PERF_EN
  output logic [31:0]                perf_words,
  output logic [15:0]                perf_bursts,
`endif
  output logic                       err_sync
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int IDL_W = $clog2(IDLE_TO + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   gnt, gnt_nxt, gnt_inc;
  logic [TAG_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   word_cnt, word_nxt;
  logic [IDL_W-1:0]   idle_cnt, idle_nxt;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 pick_found;
  logic [TAG_W-1:0]     pick_off, pick_idx;
  logic [TAG_W:0]       pick_sum;

  logic                 sel_valid, sel_last;
  logic [DATA_W-1:0]    sel_data;
  logic [1:0]           sel_mode;
  logic                 xfer, end_xfer;

  logic [IQMU_LAT-1:0]  pipe_valid, pipe_last;
  logic [TAG_W-1:0]     pipe_tag [IQMU_LAT];

  // Rotate the valid vector so that bit 0 is the stream at ptr; the lowest set bit wins.
  assign valid_dbl = {req_valid, req_valid};
  assign valid_rot = valid_dbl[{1'b0, ptr} +: NUM_REQ];

  always_comb begin
    pick_found = |valid_rot;
    pick_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) pick_off = TAG_W'(k);
    end
    pick_sum = {1'b0, ptr} + {1'b0, pick_off};
    if (pick_sum >= (TAG_W+1)'(NUM_REQ))
      pick_idx = TAG_W'(pick_sum - (TAG_W+1)'(NUM_REQ));
    else
      pick_idx = pick_sum[TAG_W-1:0];
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_mode  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == TAG_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DATA_W +: DATA_W];
        sel_mode     = req_mode[2*i +: 2];
        req_ready[i] = (state == BURST);
      end
    end
  end

  assign gnt_inc = (gnt == TAG_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    word_nxt  = word_cnt;
    idle_nxt  = idle_cnt;
    xfer      = 1'b0;
    end_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BURST;
          gnt_nxt   = pick_idx;
          word_nxt  = '0;
          idle_nxt  = '0;
        end
      end
      BURST: begin
        if (sel_valid) begin
          xfer     = 1'b1;
          idle_nxt = '0;
          word_nxt = word_cnt + 1'b1;
          if (word_cnt == CNT_W'(BURST_LEN - 1) || sel_last) begin
            end_xfer  = 1'b1;
            state_nxt = IDLE;
            ptr_nxt   = gnt_inc;
          end
        end else if (idle_cnt == IDL_W'(IDLE_TO - 1)) begin
          // Requester went quiet: release without a last marker.
          state_nxt = IDLE;
          ptr_nxt   = gnt_inc;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      word_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      ptr      <= ptr_nxt;
      word_cnt <= word_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  assign iq_valid = xfer;
  assign iq_data  = xfer ? sel_data : '0;
  assign iq_mode  = xfer ? sel_mode : '0;

  // Sideband delay line matched to the iqmu latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int s = 0; s < IQMU_LAT; s++) pipe_tag[s] <= '0;
    end else begin
      pipe_valid[0] <= xfer;
      pipe_last[0]  <= end_xfer;
      pipe_tag[0]   <= gnt;
      for (int s = 1; s < IQMU_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_last[s]  <= pipe_last[s-1];
        pipe_tag[s]   <= pipe_tag[s-1];
      end
    end
  end

  assign out_valid = pipe_valid[IQMU_LAT-1];
  assign out_last  = pipe_valid[IQMU_LAT-1] & pipe_last[IQMU_LAT-1];
  assign out_tag   = pipe_valid[IQMU_LAT-1] ? pipe_tag[IQMU_LAT-1] : '0;
  assign out_data  = iq_data_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sync <= 1'b0;
    else if (iq_valid_out != pipe_valid[IQMU_LAT-1])
      err_sync <= 1'b1;
  end

`ifdef IQMU_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_words  <= '0;
      perf_bursts <= '0;
    end else begin
      if (xfer) perf_words <= perf_words + 1'b1;
      if (state == IDLE && pick_found) perf_bursts <= perf_bursts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iqmu_sched.sv
// Randomized bench for iqmu_sched against a transaction-level scheduling model
// and a stand-in iqmu (saturating left shift by quality mode).
module tb_iqmu_sched;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int BL  = 16;
  localparam int LAT = 2;
  localparam int ITO = 8;
  localparam int TW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [N*2-1:0]  req_mode;
  logic            iq_valid, iq_valid_out;
  logic [DW-1:0]   iq_data, iq_data_out;
  logic [1:0]      iq_mode;
  logic            out_valid, out_last, err_sync;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_tag;
`ifdef IQMU_SCHED_PERF_EN
  logic [31:0]     perf_words;
  logic [15:0]     perf_bursts;
`endif
  logic            force_bad = 1'b0;

  always #5 clk = ~clk;

  iqmu_sched #(.NUM_REQ(N), .DATA_W(DW), .BURST_LEN(BL), .IQMU_LAT(LAT), .IDLE_TO(ITO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_mode(req_mode),
    .req_ready(req_ready),
    .iq_valid(iq_valid), .iq_data(iq_data), .iq_mode(iq_mode),
    .iq_valid_out(iq_valid_out), .iq_data_out(iq_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_last(out_last),
`ifdef IQMU_SCHED_PERF_EN
    .perf_words(perf_words), .perf_bursts(perf_bursts),
`endif
    .err_sync(err_sync)
  );

  function automatic logic [15:0] satShift(input logic [15:0] x, input logic [1:0] m);
    int v;
    v = int'($signed(x)) * (1 << m);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  // Stand-in iqmu with LAT cycles of latency; force_bad corrupts its valid.
  logic [LAT-1:0] iqm_v;
  logic [DW-1:0]  iqm_d [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iqm_v <= '0;
      for (int s = 0; s < LAT; s++) iqm_d[s] <= '0;
    end else begin
      iqm_v[0] <= iq_valid;
      iqm_d[0] <= iq_valid ? satShift(iq_data, iq_mode) : '0;
      for (int s = 1; s < LAT; s++) begin
        iqm_v[s] <= iqm_v[s-1];
        iqm_d[s] <= iqm_d[s-1];
      end
    end
  end
  assign iq_valid_out = iqm_v[LAT-1] ^ force_bad;
  assign iq_data_out  = iqm_d[LAT-1];

  typedef struct {
    int            due;
    int            tag;
    logic [DW-1:0] data;
    bit            last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, bad_at = -1;
  int   m_grant = -1, m_first = 0, m_served = 0, m_quiet = 0;
  int   m_words = 0, m_bursts = 0;
  bit   m_err = 0;
  int   pick;
  bit   xfer_now, last_now;
  logic [N-1:0]  exp_ready;
  logic          exp_iqv;
  logic [DW-1:0] exp_iqd;
  logic [1:0]    exp_iqm;

  int src_total[N], src_sent[N], src_prob[N], src_mode[N], src_base[N], src_step[N], src_lastmod[N];

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic setSrc(input int i, input int total, input int prob, input int mode,
                        input int base, input int step, input int lastmod);
    src_total[i] = total; src_sent[i] = 0; src_prob[i] = prob; src_mode[i] = mode;
    src_base[i] = base; src_step[i] = step; src_lastmod[i] = lastmod;
  endtask

  task automatic randomSources();
    for (int i = 0; i < N; i++)
      setSrc(i, int'($urandom_range(40, 5)), int'($urandom_range(100, 30)), -1,
             int'($urandom), int'($urandom_range(1, 0)), int'($urandom_range(7, 0)));
  endtask

  // Drive one cycle of stream activity and predict what the scheduler must do with it.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      bit v;
      v = (src_sent[i] < src_total[i]) && ($urandom_range(99) < src_prob[i]);
      req_valid[i] = v;
      req_data[i*DW +: DW] = v ? 16'(src_base[i] + src_step[i] * src_sent[i]) : 16'($urandom);
      req_mode[2*i +: 2]   = (src_mode[i] < 0) ? 2'($urandom) : 2'(src_mode[i]);
      req_last[i] = v ? (src_lastmod[i] > 0 && (src_sent[i] + 1) % src_lastmod[i] == 0)
                      : 1'($urandom);
    end
    force_bad = (cyc == bad_at);
    exp_ready = '0; exp_iqv = 1'b0; exp_iqd = '0; exp_iqm = '0;
    pick = -1; xfer_now = 0; last_now = 0;
    if (m_grant < 0) begin
      for (int k = 0; k < N; k++)
        if (pick < 0 && req_valid[(m_first + k) % N]) pick = (m_first + k) % N;
    end else begin
      exp_ready[m_grant] = 1'b1;
      if (req_valid[m_grant]) begin
        xfer_now = 1;
        exp_iqv  = 1'b1;
        exp_iqd  = req_data[m_grant*DW +: DW];
        exp_iqm  = req_mode[2*m_grant +: 2];
        last_now = (m_served + 1 == BL) || req_last[m_grant];
        exp_q.push_back('{cyc + LAT, m_grant, satShift(exp_iqd, exp_iqm), last_now});
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("req_ready", req_ready, exp_ready);
    checkVal("iq_valid", iq_valid, exp_iqv);
    checkVal("iq_data", iq_data, exp_iqd);
    checkVal("iq_mode", iq_mode, exp_iqm);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      checkVal("out_valid", out_valid, 1);
      checkVal("out_tag", out_tag, exp_q[0].tag);
      checkVal("out_last", out_last, exp_q[0].last);
      checkVal("out_data", out_data, exp_q[0].data);
    end else begin
      checkVal("out_valid_idle", out_valid, 0);
      checkVal("out_tag_idle", out_tag, 0);
      checkVal("out_last_idle", out_last, 0);
    end
    checkVal("err_sync", err_sync, m_err);
  endtask

  task automatic stepCycle();
    applyStimulus();
    #4;
    checkOutput();
    @(posedge clk);
    #1;
    if (m_grant < 0) begin
      if (pick >= 0) begin
        m_grant = pick; m_served = 0; m_quiet = 0; m_bursts++;
      end
    end else if (xfer_now) begin
      m_served++; m_quiet = 0; m_words++; src_sent[m_grant]++;
      if (last_now) begin
        m_first = (m_grant + 1) % N; m_grant = -1;
      end
    end else begin
      m_quiet++;
      if (m_quiet == ITO) begin
        m_first = (m_grant + 1) % N; m_grant = -1;
      end
    end
    if (force_bad) m_err = 1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    cyc++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) src_total[i] = src_sent[i];
    runCycles(LAT + 2);
    checkVal("drain_pending", exp_q.size(), 0);
  endtask

  // Asserts reset part-way through the current cycle with stimulus still applied.
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    checkVal("rst_req_ready", req_ready, 0);
    checkVal("rst_iq_valid", iq_valid, 0);
    checkVal("rst_iq_data", iq_data, 0);
    checkVal("rst_iq_mode", iq_mode, 0);
    checkVal("rst_out_valid", out_valid, 0);
    checkVal("rst_out_tag", out_tag, 0);
    checkVal("rst_out_last", out_last, 0);
    checkVal("rst_out_data", out_data, 0);
    checkVal("rst_err_sync", err_sync, 0);
`ifdef IQMU_SCHED_PERF_EN
    checkVal("rst_perf_words", perf_words, 0);
    checkVal("rst_perf_bursts", perf_bursts, 0);
`endif
    m_grant = -1; m_first = 0; m_served = 0; m_quiet = 0; m_err = 0;
    m_words = 0; m_bursts = 0; bad_at = -1; force_bad = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) setSrc(i, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    applyStimulus();
    doReset();

    $display("[TB] stream 0 alone, 20 words, mode 2");
    setSrc(0, 20, 100, 2, 1, 1, 0);
    runCycles(40);
    drain();
`ifdef IQMU_SCHED_PERF_EN
    checkVal("perf_words", perf_words, m_words);
    checkVal("perf_bursts", perf_bursts, m_bursts);
`endif

    $display("[TB] all streams continuously valid");
    for (int i = 0; i < N; i++) setSrc(i, 24, 100, -1, i * 256, 1, 0);
    runCycles(170);
    drain();

    $display("[TB] interleaved saturating modes on streams 1 and 2");
    setSrc(1, 6, 100, 3, 'h1000, 0, 1);
    setSrc(2, 6, 100, 0, 'h8000, 0, 1);
    runCycles(40);
    drain();

    $display("[TB] stream 3 ends early with req_last on word 5");
    setSrc(0, 4, 100, 1, 'h10, 1, 0);
    setSrc(2, 4, 100, 1, 'h20, 1, 0);
    setSrc(3, 5, 100, 2, 'h300, 1, 5);
    runCycles(60);
    drain();

    $display("[TB] random traffic");
    randomSources();
    runCycles(300);
    drain();

    $display("[TB] random traffic with iqmu valid glitch and mid-burst reset");
    randomSources();
    bad_at = cyc + 40;
    runCycles(120);
    applyStimulus();
    doReset();
    runCycles(200);
    drain();

    randomSources();
    runCycles(300);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
